// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizes and filters the raw PS/2 lines, shifts in 11-bit frames
// and reports each completed frame as a good byte or a frame/parity/timeout error strobe.
module ps2_rx_ctrl #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rx_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       err_frame,
   output logic       err_parity,
   output logic       err_timeout,
   output logic       busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic [7:0]    filt_cnt_q;
   logic          filt_q, fall_q;
   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [10:0]   frame_q, frame_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          terr_q, terr_d;
   logic          busy_q;
   logic          to_hit;

   // Input conditioning: two-stage synchronizers, then a run-length filter on the clock line.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_cnt_q <= 8'd0;
         filt_q     <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_data};
         fall_q     <= 1'b0;
         if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
               filt_q     <= ~filt_q;
               filt_cnt_q <= 8'd0;
               fall_q     <= filt_q;
            end else begin
               filt_cnt_q <= filt_cnt_q + 8'd1;
            end
         end else begin
            filt_cnt_q <= 8'd0;
         end
      end
   end

   // Registered error is due TIMEOUT_CYCLES after the last fall, so fire one cycle early here.
   assign to_hit = (32'(tcnt_q) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      frame_d = frame_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      terr_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fall_q && rx_en) begin
               frame_d = {frame_q[9:0], dat_sync_q[1]};
               cnt_d   = 4'd1;
               tcnt_d  = '0;
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (fall_q) begin
               frame_d = {frame_q[9:0], dat_sync_q[1]};
               cnt_d   = cnt_q + 4'd1;
               tcnt_d  = '0;
               if (cnt_q == 4'd10) state_d = StCheck;
            end else if (to_hit) begin
               terr_d  = 1'b1;
               cnt_d   = 4'd0;
               tcnt_d  = '0;
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StCheck: begin
            if (frame_q[10] || !frame_q[0]) begin
               ferr_d = 1'b1;
            end else if (!(^frame_q[9:1])) begin
               perr_d = 1'b1;
            end else begin
               valid_d = 1'b1;
               for (int i = 0; i < 8; i++) data_d[i] = frame_q[9-i];
            end
            cnt_d   = 4'd0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         tcnt_q  <= '0;
         frame_q <= 11'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         terr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         frame_q <= frame_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         terr_q  <= terr_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign err_frame   = ferr_q;
   assign err_parity  = perr_q;
   assign err_timeout = terr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed and randomized frames driven on raw PS/2 pins; outcomes predicted from the injected
// errors and the byte sent, latencies bounded by sync + filter + check timing.
module tb_ps2_rx_ctrl;

   localparam int unsigned FL = 4;
   localparam int unsigned TO = 1000;
   localparam int unsigned H  = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_en = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, err_frame, err_parity, err_timeout, busy;

   ps2_rx_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
      .data_out(data_out), .data_valid(data_valid), .err_frame(err_frame),
      .err_parity(err_parity), .err_timeout(err_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0, n_ferr = 0, n_perr = 0, n_to = 0, busy_hi = 0;
   int multi = 0, strobe_busy = 0, last_strobe = 0, fall_cyc = 0;
   logic [7:0] exp_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid)  n_valid <= n_valid + 1;
      if (err_frame)   n_ferr  <= n_ferr + 1;
      if (err_parity)  n_perr  <= n_perr + 1;
      if (err_timeout) n_to    <= n_to + 1;
      if (busy)        busy_hi <= busy_hi + 1;
      if ((32'(data_valid) + 32'(err_frame) + 32'(err_parity) + 32'(err_timeout)) > 1)
         multi <= multi + 1;
      if (data_valid || err_frame || err_parity || err_timeout) begin
         last_strobe <= cyc;
         if (busy) strobe_busy <= strobe_busy + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Transmission order: start, D0..D7, parity, stop.
   function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                       input bit bad_start);
      logic [10:0] f;
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      f[10] = bad_start;
      for (int i = 0; i < 8; i++) f[9-i] = b[i];
      f[1] = ((ones % 2) == 0) ^ bad_par;
      f[0] = ~bad_stop;
      return f;
   endfunction

   task automatic send_bits(input logic [10:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[10-i];
         wait_cyc(H);
         ps2_clk  = 1'b0;
         fall_cyc = cyc;
         wait_cyc(H);
         ps2_clk  = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs,
                            input bit bst);
      logic [10:0] f;
      int v0, f0, p0, t0, b0;
      int ev, ef, ep;
      f = mk(b, bp, bs, bst);
      ev = 0; ef = 0; ep = 0;
      if (rx_en) begin
         if (bs || bst) ef = 1;
         else if (bp) ep = 1;
         else begin ev = 1; exp_data = b; end
      end
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; t0 = n_to; b0 = busy_hi;
      send_bits(f, 0, 2);
      chk({tag, ".busy_mid"}, 32'(busy), 32'(rx_en));
      send_bits(f, 3, 10);
      wait_cyc(20);
      chk({tag, ".valid"}, n_valid - v0, ev);
      chk({tag, ".err_frame"}, n_ferr - f0, ef);
      chk({tag, ".err_parity"}, n_perr - p0, ep);
      chk({tag, ".err_timeout"}, n_to - t0, 0);
      chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
      chk({tag, ".busy_end"}, 32'(busy), 0);
      if (rx_en) chk_rng({tag, ".latency"}, last_strobe - fall_cyc, FL + 3, FL + 5);
      else       chk({tag, ".busy_never"}, busy_hi - b0, 0);
   endtask

   initial begin
      int v0, f0, p0, t0, b0;
      logic [10:0] f;

      wait_cyc(3);
      chk("reset.data_out", 32'(data_out), 0);
      chk("reset.strobes", {28'd0, data_valid, err_frame, err_parity, err_timeout}, 0);
      chk("reset.busy", 32'(busy), 0);
      rst_n = 1'b1;
      wait_cyc(5);

      run_frame("good1C", 8'h1C, 1'b0, 1'b0, 1'b0);
      run_frame("par1C", 8'h1C, 1'b1, 1'b0, 1'b0);
      run_frame("stop_par", 8'h1C, 1'b1, 1'b1, 1'b0);

      // Partial frame then silence.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; t0 = n_to;
      f = mk(8'hF0, 1'b0, 1'b0, 1'b0);
      send_bits(f, 0, 4);
      wait_cyc(TO + 100);
      chk("tmo.count", n_to - t0, 1);
      chk("tmo.others", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
      chk_rng("tmo.latency", last_strobe - fall_cyc, TO + FL + 1, TO + FL + 3);
      chk("tmo.busy", 32'(busy), 0);
      chk("tmo.data_out", 32'(data_out), 32'(exp_data));
      run_frame("goodF0", 8'hF0, 1'b0, 1'b0, 1'b0);

      // Sub-filter-length glitch on the clock line.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; t0 = n_to; b0 = busy_hi;
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(100);
      chk("glitch.busy", busy_hi - b0, 0);
      chk("glitch.strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0) + (n_to - t0), 0);
      run_frame("after_glitch", 8'h33, 1'b0, 1'b0, 1'b0);

      rx_en = 1'b0;
      run_frame("rx_dis", 8'h77, 1'b0, 1'b0, 1'b0);
      rx_en = 1'b1;

      // Reset in the middle of a frame.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; t0 = n_to;
      f = mk(8'hAA, 1'b0, 1'b0, 1'b0);
      send_bits(f, 0, 5);
      rst_n = 1'b0;
      wait_cyc(1);
      chk("mid_rst.data_out", 32'(data_out), 0);
      chk("mid_rst.outs", {27'd0, data_valid, err_frame, err_parity, err_timeout, busy}, 0);
      rst_n = 1'b1;
      exp_data = 8'h00;
      wait_cyc(TO + 100);
      chk("mid_rst.strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0) + (n_to - t0), 0);
      run_frame("good5A", 8'h5A, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 10; k++) begin
         int sel;
         sel = int'($urandom_range(0, 3));
         run_frame($sformatf("rnd%0d", k), 8'($urandom), sel == 1, sel == 2, sel == 3);
      end

      chk("multi_strobe", multi, 0);
      chk("strobe_with_busy", strobe_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
